// File: rtl/sb_interconnect.sv
// sb bus NM x NS crossbar: round-robin grant, address decode, decode/timeout error responses.
// Latency: grant in the request cycle, slave valid the cycle after; read and write paths each allow one transaction in flight.
module sb_interconnect #(
  parameter int          NM       = 2,
  parameter int          NS       = 4,
  parameter int          SEL_LSB  = 28,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    sb_arvalid_m,
  output logic [NM-1:0]    sb_arready_m,
  input  logic [NM*32-1:0] sb_araddr_m,
  output logic [NM-1:0]    sb_rvalid_m,
  input  logic [NM-1:0]    sb_rready_m,
  output logic [NM*32-1:0] sb_rdata_m,
  input  logic [NM-1:0]    sb_wvalid_m,
  output logic [NM-1:0]    sb_wready_m,
  input  logic [NM*32-1:0] sb_waddr_m,
  input  logic [NM*32-1:0] sb_wdata_m,
  input  logic [NM*4-1:0]  sb_wstrb_m,
  output logic [NM-1:0]    sb_bvalid_m,
  input  logic [NM-1:0]    sb_bready_m,
  output logic [NM-1:0]    sb_bresp_m,
  output logic [NS-1:0]    sb_arvalid_s,
  input  logic [NS-1:0]    sb_arready_s,
  output logic [NS*32-1:0] sb_araddr_s,
  input  logic [NS-1:0]    sb_rvalid_s,
  output logic [NS-1:0]    sb_rready_s,
  input  logic [NS*32-1:0] sb_rdata_s,
  output logic [NS-1:0]    sb_wvalid_s,
  input  logic [NS-1:0]    sb_wready_s,
  output logic [NS*32-1:0] sb_waddr_s,
  output logic [NS*32-1:0] sb_wdata_s,
  output logic [NS*4-1:0]  sb_wstrb_s,
  input  logic [NS-1:0]    sb_bvalid_s,
  output logic [NS-1:0]    sb_bready_s,
  input  logic [NS-1:0]    sb_bresp_s
);

  localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  // Timeout fires on the last allowed busy cycle so the error state starts TIMEOUT+1 cycles after grant.
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_ERR} wstate_e;

  function automatic logic [MIW-1:0] rr_pick(input logic [NM-1:0] req, input logic [MIW-1:0] last);
    logic [MIW-1:0] pick;
    pick = last;
    for (int k = NM; k >= 1; k--) begin
      if (req[(int'(last) + k) % NM]) pick = MIW'((int'(last) + k) % NM);
    end
    return pick;
  endfunction

  // Full-width compare: any set bit above log2(NS) decodes as unmapped.
  function automatic logic sel_ok(input logic [31:0] a);
    return (a >> SEL_LSB) < 32'(NS);
  endfunction

  rstate_e        rstate_q, rstate_d;
  logic [31:0]    raddr_q, raddr_d;
  logic [SIW-1:0] rs_q, rs_d;
  logic [MIW-1:0] rg_q, rg_d, rlast_q, rlast_d, r_pick;
  logic [CW-1:0]  rcnt_q, rcnt_d;
  logic           r_sv, r_sr, r_mr, r_tmo;
  logic [31:0]    r_sd;

  wstate_e        wstate_q, wstate_d;
  logic [31:0]    waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic [SIW-1:0] ws_q, ws_d;
  logic [MIW-1:0] wg_q, wg_d, wlast_q, wlast_d, w_pick;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic           w_sv, w_sb, w_sr, w_mr, w_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rs_q     <= '0;
      rg_q     <= '0;
      rlast_q  <= MIW'(NM - 1);
      rcnt_q   <= '0;
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ws_q     <= '0;
      wg_q     <= '0;
      wlast_q  <= MIW'(NM - 1);
      wcnt_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rs_q     <= rs_d;
      rg_q     <= rg_d;
      rlast_q  <= rlast_d;
      rcnt_q   <= rcnt_d;
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ws_q     <= ws_d;
      wg_q     <= wg_d;
      wlast_q  <= wlast_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    rstate_d     = rstate_q;
    raddr_d      = raddr_q;
    rs_d         = rs_q;
    rg_d         = rg_q;
    rlast_d      = rlast_q;
    rcnt_d       = rcnt_q;
    sb_arready_m = '0;
    sb_rvalid_m  = '0;
    sb_rdata_m   = '0;
    sb_arvalid_s = '0;
    sb_araddr_s  = '0;
    sb_rready_s  = '0;
    r_pick       = rr_pick(sb_arvalid_m, rlast_q);
    r_sv         = 1'b0;
    r_sr         = 1'b0;
    r_sd         = '0;
    r_mr         = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (rs_q == SIW'(i)) begin
        r_sv = sb_rvalid_s[i];
        r_sr = sb_arready_s[i];
        r_sd = sb_rdata_s[i*32 +: 32];
      end
    end
    for (int j = 0; j < NM; j++) begin
      if (rg_q == MIW'(j)) r_mr = sb_rready_m[j];
    end
    r_tmo = TMO_EN && (rcnt_q == TMO_LAST);
    case (rstate_q)
      R_IDLE: begin
        if (rst_n && (|sb_arvalid_m)) begin
          for (int j = 0; j < NM; j++) begin
            if (r_pick == MIW'(j)) begin
              sb_arready_m[j] = 1'b1;
              raddr_d         = sb_araddr_m[j*32 +: 32];
            end
          end
          rs_d     = SIW'(raddr_d >> SEL_LSB);
          rg_d     = r_pick;
          rlast_d  = r_pick;
          rcnt_d   = '0;
          rstate_d = sel_ok(raddr_d) ? R_ADDR : R_ERR;
        end
      end
      R_ADDR: begin
        for (int i = 0; i < NS; i++) begin
          if (rs_q == SIW'(i)) begin
            sb_arvalid_s[i]         = 1'b1;
            sb_araddr_s[i*32 +: 32] = raddr_q;
          end
        end
        rcnt_d = rcnt_q + 1'b1;
        if (r_tmo)     rstate_d = R_ERR;
        else if (r_sr) rstate_d = R_DATA;
      end
      R_DATA: begin
        for (int i = 0; i < NS; i++) begin
          if (rs_q == SIW'(i)) sb_rready_s[i] = r_mr;
        end
        for (int j = 0; j < NM; j++) begin
          if (rg_q == MIW'(j)) begin
            sb_rvalid_m[j]         = r_sv;
            sb_rdata_m[j*32 +: 32] = r_sv ? r_sd : '0;
          end
        end
        rcnt_d = rcnt_q + 1'b1;
        if (r_sv && r_mr) rstate_d = R_IDLE;
        else if (r_tmo)   rstate_d = R_ERR;
      end
      R_ERR: begin
        for (int j = 0; j < NM; j++) begin
          if (rg_q == MIW'(j)) begin
            sb_rvalid_m[j]         = 1'b1;
            sb_rdata_m[j*32 +: 32] = ERR_DATA;
          end
        end
        if (r_mr) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d     = wstate_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    ws_d         = ws_q;
    wg_d         = wg_q;
    wlast_d      = wlast_q;
    wcnt_d       = wcnt_q;
    sb_wready_m  = '0;
    sb_bvalid_m  = '0;
    sb_bresp_m   = '0;
    sb_wvalid_s  = '0;
    sb_waddr_s   = '0;
    sb_wdata_s   = '0;
    sb_wstrb_s   = '0;
    sb_bready_s  = '0;
    w_pick       = rr_pick(sb_wvalid_m, wlast_q);
    w_sv         = 1'b0;
    w_sb         = 1'b0;
    w_sr         = 1'b0;
    w_mr         = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (ws_q == SIW'(i)) begin
        w_sv = sb_bvalid_s[i];
        w_sb = sb_bresp_s[i];
        w_sr = sb_wready_s[i];
      end
    end
    for (int j = 0; j < NM; j++) begin
      if (wg_q == MIW'(j)) w_mr = sb_bready_m[j];
    end
    w_tmo = TMO_EN && (wcnt_q == TMO_LAST);
    case (wstate_q)
      W_IDLE: begin
        if (rst_n && (|sb_wvalid_m)) begin
          for (int j = 0; j < NM; j++) begin
            if (w_pick == MIW'(j)) begin
              sb_wready_m[j] = 1'b1;
              waddr_d        = sb_waddr_m[j*32 +: 32];
              wdata_d        = sb_wdata_m[j*32 +: 32];
              wstrb_d        = sb_wstrb_m[j*4 +: 4];
            end
          end
          ws_d     = SIW'(waddr_d >> SEL_LSB);
          wg_d     = w_pick;
          wlast_d  = w_pick;
          wcnt_d   = '0;
          wstate_d = sel_ok(waddr_d) ? W_DATA : W_ERR;
        end
      end
      W_DATA: begin
        for (int i = 0; i < NS; i++) begin
          if (ws_q == SIW'(i)) begin
            sb_wvalid_s[i]         = 1'b1;
            sb_waddr_s[i*32 +: 32] = waddr_q;
            sb_wdata_s[i*32 +: 32] = wdata_q;
            sb_wstrb_s[i*4 +: 4]   = wstrb_q;
          end
        end
        wcnt_d = wcnt_q + 1'b1;
        if (w_tmo)     wstate_d = W_ERR;
        else if (w_sr) wstate_d = W_RESP;
      end
      W_RESP: begin
        for (int i = 0; i < NS; i++) begin
          if (ws_q == SIW'(i)) sb_bready_s[i] = w_mr;
        end
        for (int j = 0; j < NM; j++) begin
          if (wg_q == MIW'(j)) begin
            sb_bvalid_m[j] = w_sv;
            sb_bresp_m[j]  = w_sv & w_sb;
          end
        end
        wcnt_d = wcnt_q + 1'b1;
        if (w_sv && w_mr) wstate_d = W_IDLE;
        else if (w_tmo)   wstate_d = W_ERR;
      end
      W_ERR: begin
        for (int j = 0; j < NM; j++) begin
          if (wg_q == MIW'(j)) begin
            sb_bvalid_m[j] = 1'b1;
            sb_bresp_m[j]  = 1'b1;
          end
        end
        if (w_mr) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sb_interconnect.sv
// Directed bench for sb_interconnect (NM=2, NS=4, TIMEOUT=8); inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_sb_interconnect;
  localparam int NM = 2;
  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    arvalid_m, arready_m, rvalid_m, rready_m;
  logic [NM-1:0]    wvalid_m, wready_m, bvalid_m, bready_m, bresp_m;
  logic [NM*32-1:0] araddr_m, rdata_m, waddr_m, wdata_m;
  logic [NM*4-1:0]  wstrb_m;
  logic [NS-1:0]    arvalid_s, arready_s, rvalid_s, rready_s;
  logic [NS-1:0]    wvalid_s, wready_s, bvalid_s, bready_s, bresp_s;
  logic [NS*32-1:0] araddr_s, rdata_s, waddr_s, wdata_s;
  logic [NS*4-1:0]  wstrb_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sb_interconnect #(.NM(NM), .NS(NS), .SEL_LSB(28), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_arvalid_m(arvalid_m), .sb_arready_m(arready_m), .sb_araddr_m(araddr_m),
    .sb_rvalid_m(rvalid_m), .sb_rready_m(rready_m), .sb_rdata_m(rdata_m),
    .sb_wvalid_m(wvalid_m), .sb_wready_m(wready_m), .sb_waddr_m(waddr_m),
    .sb_wdata_m(wdata_m), .sb_wstrb_m(wstrb_m),
    .sb_bvalid_m(bvalid_m), .sb_bready_m(bready_m), .sb_bresp_m(bresp_m),
    .sb_arvalid_s(arvalid_s), .sb_arready_s(arready_s), .sb_araddr_s(araddr_s),
    .sb_rvalid_s(rvalid_s), .sb_rready_s(rready_s), .sb_rdata_s(rdata_s),
    .sb_wvalid_s(wvalid_s), .sb_wready_s(wready_s), .sb_waddr_s(waddr_s),
    .sb_wdata_s(wdata_s), .sb_wstrb_s(wstrb_s),
    .sb_bvalid_s(bvalid_s), .sb_bready_s(bready_s), .sb_bresp_s(bresp_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_in;
    arvalid_m = '0; araddr_m = '0; rready_m = '0;
    wvalid_m = '0; waddr_m = '0; wdata_m = '0; wstrb_m = '0; bready_m = '0;
    arready_s = '0; rvalid_s = '0; rdata_s = '0;
    wready_s = '0; bvalid_s = '0; bresp_s = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_in();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] m;
    // Reset with requests pending: nothing may be granted or driven.
    rst_n = 1'b0;
    idle_in();
    arvalid_m = 2'b11;
    wvalid_m  = 2'b11;
    cyc(); cyc(); smp();
    chk("rst_arready", arready_m, 0);
    chk("rst_wready", wready_m, 0);
    chk("rst_rvalid", rvalid_m, 0);
    chk("rst_bvalid", bvalid_m, 0);
    chk("rst_arvalid_s", arvalid_s, 0);
    chk("rst_wvalid_s", wvalid_s, 0);
    cyc();
    idle_in();
    rst_n = 1'b1;

    // Zero-wait read: m0 -> slave 1.
    cyc();
    arvalid_m = 2'b01; araddr_m[31:0] = 32'h1000_0010;
    smp();
    chk("rd_arready", arready_m, 2'b01);
    chk("rd_arvalid_s_c0", arvalid_s, 0);
    cyc();
    arvalid_m = '0; arready_s = 4'b0010;
    smp();
    chk("rd_arvalid_s_c1", arvalid_s, 4'b0010);
    chk("rd_araddr_s1", araddr_s[63:32], 32'h1000_0010);
    cyc();
    arready_s = '0; rvalid_s = 4'b0010; rdata_s[63:32] = 32'h1234_5678; rready_m = 2'b01;
    smp();
    chk("rd_arvalid_s_c2", arvalid_s, 0);
    chk("rd_rvalid_m", rvalid_m, 2'b01);
    chk("rd_rdata_m0", rdata_m[31:0], 32'h1234_5678);
    chk("rd_rready_s", rready_s, 4'b0010);
    cyc();
    idle_in();
    smp();
    chk("rd_rvalid_done", rvalid_m, 0);

    // Round-robin between two continuously requesting masters.
    do_reset();
    cyc();
    arvalid_m = 2'b11;
    araddr_m  = {32'h0000_0200, 32'h0000_0100};
    arready_s = 4'b0001; rvalid_s = 4'b0001; rdata_s[31:0] = 32'h55AA_0000; rready_m = 2'b11;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      smp();
      m = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_arready", arready_m, (c % 3 == 0) ? m : 2'b00);
      if (c % 3 == 1) chk("rr_araddr_s0", araddr_s[31:0], (m == 2'b01) ? 32'h100 : 32'h200);
      if (c % 3 == 2) begin
        chk("rr_rvalid", rvalid_m, m);
        chk("rr_rdata", (m == 2'b01) ? rdata_m[31:0] : rdata_m[63:32], 32'h55AA_0000);
      end
    end
    cyc();
    idle_in();

    // Write from m1 to slave 3.
    cyc();
    wvalid_m = 2'b10; waddr_m[63:32] = 32'h3000_0004; wdata_m[63:32] = 32'hA5A5_0000; wstrb_m[7:4] = 4'b1100;
    smp();
    chk("wr_wready", wready_m, 2'b10);
    cyc();
    wvalid_m = '0; wready_s = 4'b1000;
    smp();
    chk("wr_wvalid_s", wvalid_s, 4'b1000);
    chk("wr_waddr_s3", waddr_s[127:96], 32'h3000_0004);
    chk("wr_wdata_s3", wdata_s[127:96], 32'hA5A5_0000);
    chk("wr_wstrb_s3", wstrb_s[15:12], 4'b1100);
    cyc();
    wready_s = '0; bvalid_s = 4'b1000; bresp_s = '0; bready_m = 2'b10;
    smp();
    chk("wr_bvalid", bvalid_m, 2'b10);
    chk("wr_bresp", bresp_m, 2'b00);
    chk("wr_bready_s", bready_s, 4'b1000);
    cyc();
    idle_in();
    smp();
    chk("wr_bvalid_done", bvalid_m, 0);

    // Unmapped address: concurrent read and write error responses for m0.
    cyc();
    arvalid_m = 2'b01; araddr_m[31:0] = 32'h5000_0000;
    wvalid_m  = 2'b01; waddr_m[31:0]  = 32'h5000_0000;
    smp();
    chk("de_arready", arready_m, 2'b01);
    chk("de_wready", wready_m, 2'b01);
    cyc();
    arvalid_m = '0; wvalid_m = '0; bready_m = 2'b01;
    smp();
    chk("de_rvalid", rvalid_m, 2'b01);
    chk("de_rdata", rdata_m[31:0], 32'hDEAD_BEEF);
    chk("de_arvalid_s", arvalid_s, 0);
    chk("de_bvalid", bvalid_m, 2'b01);
    chk("de_bresp", bresp_m, 2'b01);
    chk("de_wvalid_s", wvalid_s, 0);
    cyc();
    bready_m = '0; rready_m = 2'b01;
    smp();
    chk("de_rvalid_hold", rvalid_m, 2'b01);
    chk("de_bvalid_done", bvalid_m, 0);
    cyc();
    idle_in();
    smp();
    chk("de_rvalid_done", rvalid_m, 0);

    // Write timeout on slave 2 (never ready), then a late bvalid is ignored.
    cyc();
    wvalid_m = 2'b01; waddr_m[31:0] = 32'h2000_0000; wdata_m[31:0] = 32'h1111_2222; wstrb_m[3:0] = 4'hF;
    smp();
    chk("to_wready", wready_m, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      wvalid_m = '0;
      smp();
      chk("to_wvalid_s", wvalid_s, 4'b0100);
      chk("to_bvalid_wait", bvalid_m, 0);
    end
    cyc();
    bvalid_s = 4'b0100; bready_m = 2'b01;
    smp();
    chk("to_wvalid_drop", wvalid_s, 0);
    chk("to_bvalid", bvalid_m, 2'b01);
    chk("to_bresp", bresp_m, 2'b01);
    chk("to_late_bready_s", bready_s, 0);
    cyc();
    bvalid_s = '0; bready_m = '0;
    wvalid_m = 2'b01; waddr_m[31:0] = 32'h2000_0008;
    smp();
    chk("to_idle_bvalid", bvalid_m, 0);
    chk("to_regrant", wready_m, 2'b01);
    cyc();
    wvalid_m = '0; wready_s = 4'b0100;
    smp();
    chk("to_waddr_s2", waddr_s[95:64], 32'h2000_0008);
    chk("to_wdata_s2", wdata_s[95:64], 32'h1111_2222);
    cyc();
    wready_s = '0; bvalid_s = 4'b0100; bresp_s = '0; bready_m = 2'b01;
    smp();
    chk("to_ok_bvalid", bvalid_m, 2'b01);
    chk("to_ok_bresp", bresp_m, 2'b00);
    cyc();
    idle_in();

    // Reset while in R_DATA abandons the read; master 0 wins first afterwards.
    cyc();
    arvalid_m = 2'b10; araddr_m[63:32] = 32'h1000_0000;
    smp();
    chk("mr_arready", arready_m, 2'b10);
    cyc();
    arvalid_m = '0; arready_s = 4'b0010;
    smp();
    chk("mr_arvalid_s", arvalid_s, 4'b0010);
    cyc();
    arready_s = '0; rready_m = 2'b10; rst_n = 1'b0;
    smp();
    chk("mr_rdata_route", rready_s, 4'b0010);
    cyc();
    rvalid_s = 4'b0010; rdata_s[63:32] = 32'hCAFE_0001; arvalid_m = 2'b11;
    araddr_m = {32'h0000_0000, 32'h0000_0000};
    smp();
    chk("mr_rvalid", rvalid_m, 0);
    chk("mr_rdata", rdata_m[63:32], 0);
    chk("mr_rready_s", rready_s, 0);
    chk("mr_arready", arready_m, 0);
    chk("mr_arvalid_s", arvalid_s, 0);
    cyc();
    rst_n = 1'b1;
    smp();
    chk("mr_first_grant", arready_m, 2'b01);
    cyc();
    idle_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
